// File: rtl/phase_timer.sv
// phase_timer: per-phase countdown for the traffic-light controller.
// Loads the duration of the active phase, counts it down in whole seconds
// derived from clk, raises a level carry when the phase time has elapsed,
// and presents the remaining seconds in binary and as two BCD digits.
`timescale 1ns/1ps

module phase_timer #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned T_MGCR   = 30,
  parameter int unsigned T_MYCR   = 3,
  parameter int unsigned T_MRCG   = 20,
  parameter int unsigned T_MRCY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] current_state,
  output logic       counter_carry_flag,
  output logic [6:0] remain_sec,
  output logic [3:0] remain_tens,
  output logic [3:0] remain_ones
);

  localparam int unsigned    PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    MGCR = 2'd0,
    MYCR = 2'd1,
    MRCG = 2'd2,
    MRCY = 2'd3
  } phase_t;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } fsm_t;

  logic [1:0]    state_meta;
  logic [1:0]    state_s;
  phase_t        phase_q;
  fsm_t          fsm_q;
  logic [PW-1:0] presc_q;
  logic          tick;

  // Duration in seconds for each phase code.
  function automatic logic [6:0] duration(input phase_t p);
    case (p)
      MGCR:    duration = 7'(T_MGCR);
      MYCR:    duration = 7'(T_MYCR);
      MRCG:    duration = 7'(T_MRCG);
      default: duration = 7'(T_MRCY);
    endcase
  endfunction

  // Two-flop synchronizer: current_state comes from the controller's divided clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_meta <= 2'd0;
      state_s    <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old values,
      // so this really is two stages and not a single wire.
      state_meta <= current_state;
      state_s    <= state_meta;
    end
  end

  // One-second strobe; only meaningful while counting.
  assign tick = (fsm_q == RUN) && (presc_q == PRESC_LAST);

  // Phase tracking, prescaler and countdown; a phase change outranks a tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q            <= MGCR;
      fsm_q              <= RUN;
      presc_q            <= '0;
      remain_sec         <= duration(MGCR);
      counter_carry_flag <= 1'b0;
    end else if (phase_t'(state_s) != phase_q) begin
      phase_q            <= phase_t'(state_s);
      fsm_q              <= RUN;
      presc_q            <= '0;
      remain_sec         <= duration(phase_t'(state_s));
      counter_carry_flag <= 1'b0;
    end else begin
      case (fsm_q)
        RUN: begin
          if (tick) begin
            presc_q <= '0;
            if (remain_sec == 7'd1) begin
              remain_sec         <= 7'd0;
              counter_carry_flag <= 1'b1;
              fsm_q              <= DONE;
            end else begin
              remain_sec <= remain_sec - 7'd1;
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        default: begin
          // Elapsed: park until the controller moves to another phase.
          presc_q            <= '0;
          remain_sec         <= 7'd0;
          counter_carry_flag <= 1'b1;
        end
      endcase
    end
  end

  // BCD digits straight from the register, no extra latency.
  assign remain_tens = 4'(remain_sec / 7'd10);
  assign remain_ones = 4'(remain_sec % 7'd10);

endmodule

// File: tb/tb_phase_timer.sv
// Directed self-checking bench for phase_timer.
// Three instances: defaults (reset values), a fast one for phase sequencing,
// and a TICK_DIV=2 / 99 s one for the BCD sweep.
`timescale 1ns/1ps

module tb_phase_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0] cs_def, cs_main, cs_bcd;

  logic       carry_def, carry_main, carry_bcd;
  logic [6:0] sec_def, sec_main, sec_bcd;
  logic [3:0] tens_def, tens_main, tens_bcd;
  logic [3:0] ones_def, ones_main, ones_bcd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  phase_timer u_def (
    .clk                (clk),
    .rst                (rst),
    .current_state      (cs_def),
    .counter_carry_flag (carry_def),
    .remain_sec         (sec_def),
    .remain_tens        (tens_def),
    .remain_ones        (ones_def)
  );

  phase_timer #(
    .TICK_DIV (4),
    .T_MGCR   (5),
    .T_MYCR   (3),
    .T_MRCG   (14),
    .T_MRCY   (3)
  ) u_main (
    .clk                (clk),
    .rst                (rst),
    .current_state      (cs_main),
    .counter_carry_flag (carry_main),
    .remain_sec         (sec_main),
    .remain_tens        (tens_main),
    .remain_ones        (ones_main)
  );

  phase_timer #(
    .TICK_DIV (2),
    .T_MGCR   (99),
    .T_MYCR   (7),
    .T_MRCG   (20),
    .T_MRCY   (3)
  ) u_bcd (
    .clk                (clk),
    .rst                (rst),
    .current_state      (cs_bcd),
    .counter_carry_flag (carry_bcd),
    .remain_sec         (sec_bcd),
    .remain_tens        (tens_bcd),
    .remain_ones        (ones_bcd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns so outputs are sampled off the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_sec;

    cs_def  = 2'd0;
    cs_main = 2'd0;
    cs_bcd  = 2'd0;

    // Reset values while reset is held.
    #1 rst = 1'b0;
    #1;
    check("rst_def_sec",   sec_def,   30);
    check("rst_def_tens",  tens_def,  3);
    check("rst_def_ones",  ones_def,  0);
    check("rst_def_carry", carry_def, 0);
    check("rst_main_sec",  sec_main,  5);
    check("rst_bcd_sec",   sec_bcd,   99);

    // Release between edges; counting starts at the next edge.
    step(3);
    rst = 1'b1;

    // Full mgcr countdown, D=4.
    step(3);
    check("mgcr_hold_sec",   sec_main,   5);
    check("mgcr_hold_carry", carry_main, 0);
    step(1);
    check("mgcr_4", sec_main, 4);
    step(4);
    check("mgcr_3", sec_main, 3);
    step(4);
    check("mgcr_2", sec_main, 2);
    step(4);
    check("mgcr_1",       sec_main,   1);
    check("mgcr_1_carry", carry_main, 0);
    step(4);
    check("mgcr_0",       sec_main,   0);
    check("mgcr_0_carry", carry_main, 1);
    check("def_no_dec",   sec_def,    30);

    // DONE holds without wrap.
    for (int i = 0; i < 200; i++) begin
      step(1);
      check("done_sec",   sec_main,   0);
      check("done_carry", carry_main, 1);
    end

    // Phase advance to mycr: reload on the third edge.
    cs_main = 2'd1;
    step(2);
    check("adv_pre_sec",   sec_main,   0);
    check("adv_pre_carry", carry_main, 1);
    step(1);
    check("adv_sec",   sec_main,   3);
    check("adv_carry", carry_main, 0);
    step(11);
    check("mycr_1",       sec_main,   1);
    check("mycr_1_carry", carry_main, 0);
    step(1);
    check("mycr_0",       sec_main,   0);
    check("mycr_0_carry", carry_main, 1);

    // Mid-run change: mrcg down to 12, then switch to mrcy.
    cs_main = 2'd2;
    step(3);
    check("mrcg_load", sec_main, 14);
    step(8);
    check("mrcg_12", sec_main, 12);
    cs_main = 2'd3;
    step(2);
    check("mid_pre_sec", sec_main, 12);
    step(1);
    check("mid_sec",   sec_main,   3);
    check("mid_carry", carry_main, 0);
    step(3);
    check("mid_no_stale", sec_main, 3);
    step(1);
    check("mrcy_2", sec_main, 2);

    // Reload lands on the same edge as a tick.
    step(1);
    cs_main = 2'd0;
    step(2);
    check("sim_pre_sec", sec_main, 2);
    step(1);
    check("sim_sec",   sec_main,   5);
    check("sim_carry", carry_main, 0);
    step(3);
    check("sim_presc_restart", sec_main, 5);
    step(1);
    check("sim_first_dec", sec_main, 4);

    // BCD sweep: reload 99 on the bcd instance and count down with D=2.
    cs_bcd = 2'd1;
    step(3);
    check("bcd_mycr", sec_bcd, 7);
    cs_bcd = 2'd0;
    step(3);
    check("bcd_load_sec",  sec_bcd,  99);
    check("bcd_load_tens", tens_bcd, 9);
    check("bcd_load_ones", ones_bcd, 9);
    for (int k = 1; k <= 200; k++) begin
      step(1);
      exp_sec = (k / 2 >= 99) ? 0 : 99 - k / 2;
      check("bcd_sec",   sec_bcd,   exp_sec);
      check("bcd_tens",  tens_bcd,  exp_sec / 10);
      check("bcd_ones",  ones_bcd,  exp_sec % 10);
      check("bcd_carry", carry_bcd, (k >= 198) ? 1 : 0);
    end

    // Reset mid-operation.
    cs_main = 2'd1;
    cs_bcd  = 2'd1;
    step(7);
    check("pre_rst_main", sec_main, 2);
    check("pre_rst_bcd",  sec_bcd,  5);
    rst = 1'b0;
    #1;
    check("mid_rst_main_sec",   sec_main,   5);
    check("mid_rst_main_carry", carry_main, 0);
    check("mid_rst_bcd_sec",    sec_bcd,    99);
    check("mid_rst_def_sec",    sec_def,    30);
    cs_main = 2'd0;
    cs_bcd  = 2'd0;
    step(2);
    rst = 1'b1;
    step(3);
    check("post_rst_main_hold", sec_main, 5);
    check("post_rst_bcd",       sec_bcd,  98);
    step(1);
    check("post_rst_main_dec", sec_main, 4);
    check("post_rst_bcd_dec",  sec_bcd,  97);
    check("post_rst_def",      sec_def,  30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
